// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder
//   Multi-digit packed-BCD adder that walks the operands one decimal digit
//   per clock, least-significant digit first, through a single 4-bit BCD
//   digit-add stage. A start/busy/done handshake frames each operation.
//
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : operation request, sampled only when not busy (IDLE or FIN)
//   a, b   : packed-BCD operands, digit i at [4i+3:4i]
//   cin    : decimal carry into digit 0
//   busy   : high while digits are being processed
//   done   : one-cycle pulse when sum/cout/err hold a fresh result
//   sum    : packed-BCD result, held until the next completion
//   cout   : decimal carry out of the top digit
//   err    : some input digit of the last operation was above 9
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t state_reg, state_next;

    logic [W-1:0]  a_reg, b_reg;
    logic [W-1:0]  work_reg, work_next;
    logic [W-1:0]  sum_reg;
    logic [IW-1:0] idx_reg;
    logic          carry_reg;
    logic          err_acc_reg;
    logic          cout_reg;
    logic          err_reg;

    // Digit views of the shadow operands, selected by the running index
    logic [3:0] a_dig [DIGITS];
    logic [3:0] b_dig [DIGITS];
    logic [3:0] x_dig, y_dig;
    logic [4:0] t_bin;
    logic       dc;
    logic [3:0] d_sum;
    logic       dig_bad;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign a_dig[gi] = a_reg[4*gi +: 4];
            assign b_dig[gi] = b_reg[4*gi +: 4];
            // Working result with the digit being processed this cycle merged in,
            // so the completion edge can publish all digits at once.
            assign work_next[4*gi +: 4] = (idx_reg == IW'(gi)) ? d_sum : work_reg[4*gi +: 4];
        end
    endgenerate

    // Single shared BCD digit-add stage
    assign x_dig   = a_dig[idx_reg];
    assign y_dig   = b_dig[idx_reg];
    assign t_bin   = {1'b0, x_dig} + {1'b0, y_dig} + {4'b0000, carry_reg};
    // Decimal carry whenever the binary digit sum reaches 10 or more
    assign dc      = t_bin[4] | (t_bin[3] & t_bin[2]) | (t_bin[3] & t_bin[1]);
    // +6 correction wraps modulo 16; invalid digits are not saturated
    assign d_sum   = t_bin[3:0] + (dc ? 4'd6 : 4'd0);
    assign dig_bad = (x_dig > 4'd9) | (y_dig > 4'd9);

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (idx_reg == LAST_IDX) state_next = FIN;
            end
            FIN: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            work_reg    <= '0;
            sum_reg     <= '0;
            idx_reg     <= '0;
            carry_reg   <= 1'b0;
            err_acc_reg <= 1'b0;
            cout_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                // FIN accepts a new start so operations can run back to back
                IDLE, FIN: begin
                    if (start) begin
                        a_reg       <= a;
                        b_reg       <= b;
                        carry_reg   <= cin;
                        idx_reg     <= '0;
                        work_reg    <= '0;
                        err_acc_reg <= 1'b0;
                    end
                end
                RUN: begin
                    work_reg    <= work_next;
                    carry_reg   <= dc;
                    err_acc_reg <= err_acc_reg | dig_bad;
                    idx_reg     <= idx_reg + IW'(1);
                    if (idx_reg == LAST_IDX) begin
                        sum_reg  <= work_next;
                        cout_reg <= dc;
                        err_reg  <= err_acc_reg | dig_bad;
                        idx_reg  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder
//   Scoreboard bench: the driver pushes the reference result of each accepted
//   operation into a queue; an independent monitor pops and compares on every
//   done pulse and checks that the outputs hold steady between pulses.
module tb_bcd_serial_adder;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int LAT    = DIGITS + 1;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    int   compared   = 0;
    int   mismatched = 0;
    int   txn        = 0;
    exp_t sb_q[$];
    exp_t held;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal addition digit by digit from the arithmetic rule: a digit sum of
    // ten or more produces a carry and the digit (t+6) mod 16.
    function automatic exp_t ref_add(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
        exp_t r;
        int   carry;
        r.sum = '0;
        r.err = 1'b0;
        carry = xc ? 1 : 0;
        for (int i = 0; i < DIGITS; i++) begin
            int dx;
            int dy;
            int t;
            dx = int'(xa[4*i +: 4]);
            dy = int'(xb[4*i +: 4]);
            t  = dx + dy + carry;
            if (dx > 9 || dy > 9) r.err = 1'b1;
            if (t >= 10) begin
                r.sum[4*i +: 4] = 4'((t + 6) % 16);
                carry = 1;
            end else begin
                r.sum[4*i +: 4] = 4'(t);
                carry = 0;
            end
        end
        r.cout = (carry != 0);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_operand(input bit allow_bad);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if ($urandom_range(0, 2) == 0) v[4*i +: 4] = 4'd9;
            else v[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        if (allow_bad) v[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    // Monitor: compare on done, otherwise require the published result to hold
    always @(negedge clk) begin
        if (!rst_n) begin
            held = '0;
        end else if (done) begin
            exp_t e;
            compared++;
            if (busy !== 1'b0) begin
                mismatched++;
                $display("FAIL busy_in_fin: busy=%b required 0", busy);
            end
            compared++;
            if (sb_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_done: done=1 with no operation pending (sum=%h)", sum);
            end else begin
                e = sb_q.pop_front();
                txn++;
                $display("txn %0d: sum=%h cout=%0d err=%0d (expected sum=%h cout=%0d err=%0d)",
                         txn, sum, cout, err, e.sum, e.cout, e.err);
                if ({sum, cout, err} !== {e.sum, e.cout, e.err}) begin
                    mismatched++;
                    $display("FAIL result: got sum=%h cout=%b err=%b required sum=%h cout=%b err=%b",
                             sum, cout, err, e.sum, e.cout, e.err);
                end
                held = e;
            end
        end else begin
            compared++;
            if ({sum, cout, err} !== {held.sum, held.cout, held.err}) begin
                mismatched++;
                $display("FAIL hold: got sum=%h cout=%b err=%b required sum=%h cout=%b err=%b",
                         sum, cout, err, held.sum, held.cout, held.err);
            end
        end
    end

    // Drive one start cycle; inputs are scrambled afterwards to prove they are
    // not re-sampled during the run.
    task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
        a     = xa;
        b     = xb;
        cin   = xc;
        start = 1'b1;
        sb_q.push_back(ref_add(xa, xb, xc));
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom_range(0, 1));
    endtask

    // Wait (bounded) for done; n0 negedges already elapsed since the start edge.
    // Returns on the negedge where done is seen, i.e. inside the FIN cycle.
    task automatic wait_done(input int n0, input int exp_lat);
        int n;
        bit busy_ok;
        n       = n0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (!done && !busy) busy_ok = 1'b0;
        end while (!done && n < 64);
        compared++;
        if (!done) begin
            mismatched++;
            $display("FAIL timeout: done not seen within %0d cycles", n);
        end else if (n != exp_lat) begin
            mismatched++;
            $display("FAIL latency: got %0d cycles required %0d", n, exp_lat);
        end
        compared++;
        if (!busy_ok) begin
            mismatched++;
            $display("FAIL busy_during_run: busy dropped before done, required 1");
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        compared++;
        if (got !== req) begin
            mismatched++;
            $display("FAIL %s: got %b required %b", name, got, req);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #1;
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_done", done, 1'b0);
        check_bit("reset_cout", cout, 1'b0);
        check_bit("reset_err", err, 1'b0);
        check_bit("reset_sum_zero", (sum == '0), 1'b1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(16'h1234, 16'h5678, 1'b0); wait_done(0, LAT);
        issue(16'h9999, 16'h0001, 1'b0); wait_done(0, LAT);
        issue(16'h4999, 16'h5000, 1'b1); wait_done(0, LAT);
        issue(16'h00A0, 16'h0000, 1'b0); wait_done(0, LAT);
        issue(16'h0000, 16'h0000, 1'b1); wait_done(0, LAT);
        @(negedge clk);

        // start while busy is ignored, then a back-to-back start in FIN
        issue(16'h0005, 16'h0005, 1'b0);
        @(negedge clk);
        start = 1'b1;
        a     = 16'h1111;
        b     = 16'h1111;
        cin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done(2, LAT);
        issue(16'h1111, 16'h1111, 1'b0);
        wait_done(0, LAT);
        repeat (6) @(negedge clk);

        // Reset in the middle of a run
        issue(16'h1234, 16'h1111, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        sb_q.delete();
        #1;
        check_bit("midreset_busy", busy, 1'b0);
        check_bit("midreset_done", done, 1'b0);
        check_bit("midreset_cout", cout, 1'b0);
        check_bit("midreset_err", err, 1'b0);
        check_bit("midreset_sum_zero", (sum == '0), 1'b1);
        repeat (3) begin
            @(negedge clk);
            check_bit("midreset_no_done", done, 1'b0);
        end
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        issue(16'h2468, 16'h1357, 1'b1); wait_done(0, LAT);
        @(negedge clk);

        // Randomized operations with random gaps and back-to-back starts
        for (int k = 0; k < 60; k++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = rand_operand($urandom_range(0, 5) == 0);
            rb = rand_operand($urandom_range(0, 5) == 0);
            issue(ra, rb, 1'($urandom_range(0, 1)));
            wait_done(0, LAT);
            if ($urandom_range(0, 2) != 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        repeat (8) @(negedge clk);
        compared++;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d results pending required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
